// File: rtl/axis_downsizer.sv
// AXI-Stream width down-converter: each accepted wide word is replayed as
// RATIO narrow beats, least-significant slice first, with no bubbles between words.
module axis_downsizer #(
  parameter int AXIS_I_BYTES = 4,
  parameter int AXIS_O_BYTES = 1
) (
  input  logic                      clk,
  input  logic                      sresetn,
  output logic                      axis_i_tready,
  input  logic                      axis_i_tvalid,
  input  logic                      axis_i_tlast,
  input  logic [AXIS_I_BYTES*8-1:0] axis_i_tdata,
  input  logic                      axis_o_tready,
  output logic                      axis_o_tvalid,
  output logic                      axis_o_tlast,
  output logic [AXIS_O_BYTES*8-1:0] axis_o_tdata
);

  localparam int O_BYTES_SAFE = (AXIS_O_BYTES <= 0) ? 1 : AXIS_O_BYTES;
  localparam int RATIO_RAW    = AXIS_I_BYTES / O_BYTES_SAFE;
  localparam int RATIO        = (RATIO_RAW < 1) ? 1 : RATIO_RAW;
  localparam int OW           = O_BYTES_SAFE * 8;
  localparam int IDX_W        = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

  if ((AXIS_O_BYTES <= 0) || (AXIS_I_BYTES % O_BYTES_SAFE != 0)) begin : gBadParams
    $error("axis_downsizer: AXIS_I_BYTES must be a non-zero multiple of AXIS_O_BYTES");
  end

  logic [RATIO-1:0][OW-1:0] bufData_q, bufData_d;
  logic                     bufLast_q, bufLast_d;
  logic                     full_q, full_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic                     atLast;
  logic                     inXfer;
  logic                     outXfer;

  assign atLast        = (idx_q == LAST_IDX);
  assign axis_i_tready = !full_q || (axis_o_tready && atLast);
  assign inXfer        = axis_i_tvalid && axis_i_tready;
  assign outXfer       = full_q && axis_o_tready;

  assign axis_o_tvalid = full_q;
  assign axis_o_tdata  = bufData_q[idx_q];
  assign axis_o_tlast  = bufLast_q && atLast;

  // A load takes priority: it covers both the empty case and refilling while the final slice leaves.
  always_comb begin
    full_d    = full_q;
    idx_d     = idx_q;
    bufData_d = bufData_q;
    bufLast_d = bufLast_q;
    if (inXfer) begin
      bufData_d = axis_i_tdata;
      bufLast_d = axis_i_tlast;
      full_d    = 1'b1;
      idx_d     = '0;
    end else if (outXfer && atLast) begin
      full_d = 1'b0;
      idx_d  = '0;
    end else if (outXfer) begin
      idx_d = idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!sresetn) begin
      full_q <= 1'b0;
      idx_q  <= '0;
    end else begin
      full_q <= full_d;
      idx_q  <= idx_d;
    end
  end

  // The holding register is qualified by full_q, so it needs no reset.
  always_ff @(posedge clk) begin
    bufData_q <= bufData_d;
    bufLast_q <= bufLast_d;
  end

endmodule
